// File: rtl/sr_trace_buffer.sv
// sr_trace_buffer: {pc, instr} retirement trace capture (ring or one-shot) with timeout and self-loop halt detect.
// Read latency 1 cycle, no backpressure on trace beats; SR_TRACE_TRIGGER_EN adds a trigger-PC start (ARMED state).
module sr_trace_buffer #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 16,
  parameter int MODE        = 0,
  parameter int MAX_CYCLES  = 30,
  parameter int HALT_REPEAT = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      arm,
  input  logic                      trace_valid,
  input  logic [ADDR_W-1:0]         trace_pc,
  input  logic [31:0]               trace_instr,
  input  logic [ADDR_W-1:0]         trig_pc,
  input  logic                      rd_en,
  input  logic [$clog2(DEPTH)-1:0]  rd_idx,
  output logic [ADDR_W+31:0]        rd_data,
  output logic                      rd_valid,
  output logic [1:0]                state,
  output logic [$clog2(DEPTH):0]    count,
  output logic [31:0]               cycle_cnt,
  output logic                      timeout,
  output logic                      halted
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam int ENT_W = ADDR_W + 32;

  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [IDX_W-1:0] PTR_LAST  = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] PTR_ONE   = IDX_W'(1);
  localparam logic [31:0]      CYC_LIMIT = 32'(MAX_CYCLES);
  localparam logic [31:0]      REP_LIMIT = 32'(HALT_REPEAT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_e;

`ifdef SR_TRACE_TRIGGER_EN
  localparam state_e ARM_STATE = S_ARMED;
  logic trig_hit;
  assign trig_hit = (trace_pc == trig_pc);
`else
  localparam state_e ARM_STATE = S_CAPTURE;
  logic trig_hit;
  logic unused_trig;
  assign trig_hit    = 1'b0;
  assign unused_trig = ^trig_pc;
`endif

  logic [ENT_W-1:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic              wrap_q, wrap_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [31:0]       cycle_q, cycle_d;
  logic              timeout_q, timeout_d;
  logic              halted_q, halted_d;
  logic [31:0]       rep_q, rep_d;
  logic [ADDR_W-1:0] last_pc_q, last_pc_d;
  logic              rd_valid_q, rd_valid_d;
  logic [ENT_W-1:0]  rd_data_q, rd_data_d;

  logic              beat_live;
  logic              wr_en;
  logic              rd_hit;
  logic [IDX_W-1:0]  rd_phys;

  // A beat coinciding with arm is dropped; DONE and IDLE ignore beats.
  assign beat_live = trace_valid && !arm && (state_q == S_ARMED || state_q == S_CAPTURE);
  assign wr_en     = beat_live && (state_q == S_CAPTURE || trig_hit);

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    wrap_d    = wrap_q;
    count_d   = count_q;
    cycle_d   = cycle_q;
    timeout_d = timeout_q;
    halted_d  = halted_q;
    rep_d     = rep_q;
    last_pc_d = last_pc_q;

    if (arm) begin
      state_d   = ARM_STATE;
      wr_ptr_d  = '0;
      wrap_d    = 1'b0;
      count_d   = '0;
      cycle_d   = '0;
      timeout_d = 1'b0;
      halted_d  = 1'b0;
      rep_d     = '0;
    end else if (beat_live) begin
      if (cycle_q != '1) begin
        cycle_d = cycle_q + 32'd1;
      end
      if (wr_en) begin
        state_d   = S_CAPTURE;
        wr_ptr_d  = wr_ptr_q + PTR_ONE;
        last_pc_d = trace_pc;
        if (wr_ptr_q == PTR_LAST) begin
          wrap_d = 1'b1;
        end
        if (count_q != CNT_FULL) begin
          count_d = count_q + CNT_ONE;
        end
        // count_q is nonzero only when a previous beat since arm exists to compare against.
        if (count_q != '0 && trace_pc == last_pc_q) begin
          if (rep_q != '1) begin
            rep_d = rep_q + 32'd1;
          end
        end else begin
          rep_d = 32'd1;
        end
        if (MODE == 1 && count_d == CNT_FULL) begin
          state_d = S_DONE;
        end
        if (HALT_REPEAT != 0 && rep_d == REP_LIMIT) begin
          halted_d = 1'b1;
          state_d  = S_DONE;
        end
      end
      if (MAX_CYCLES != 0 && cycle_d == CYC_LIMIT) begin
        timeout_d = 1'b1;
        state_d   = S_DONE;
      end
    end
  end

  // Logical index 0 is the oldest entry; once a ring has wrapped, that is the slot at wr_ptr.
  always_comb begin
    rd_hit     = rd_en && ({1'b0, rd_idx} < count_q);
    rd_phys    = (MODE == 0 && wrap_q) ? (wr_ptr_q + rd_idx) : rd_idx;
    rd_valid_d = rd_hit;
    rd_data_d  = rd_hit ? mem[rd_phys] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      mem[wr_ptr_q] <= {trace_pc, trace_instr};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      wrap_q     <= 1'b0;
      count_q    <= '0;
      cycle_q    <= '0;
      timeout_q  <= 1'b0;
      halted_q   <= 1'b0;
      rep_q      <= '0;
      last_pc_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      wrap_q     <= wrap_d;
      count_q    <= count_d;
      cycle_q    <= cycle_d;
      timeout_q  <= timeout_d;
      halted_q   <= halted_d;
      rep_q      <= rep_d;
      last_pc_q  <= last_pc_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign state     = state_q;
  assign count     = count_q;
  assign cycle_cnt = cycle_q;
  assign timeout   = timeout_q;
  assign halted    = halted_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_sr_trace_buffer.sv
// Bench for sr_trace_buffer: four configurations share one directed stimulus and are checked every cycle
// against a history-based model, plus hand-computed literal expectations.
module tb_sr_trace_buffer;

  localparam int NI = 4;
  localparam int P_DEPTH [NI] = '{4, 4, 8, 16};
  localparam int P_MODE  [NI] = '{0, 1, 0, 0};
  localparam int P_MAX   [NI] = '{0, 30, 30, 30};
  localparam int P_HALT  [NI] = '{3, 0, 3, 3};
  localparam int HMAX = 64;

`ifdef SR_TRACE_TRIGGER_EN
  localparam int ARM_EXP = 1;
  localparam bit TRIG_EN = 1'b1;
`else
  localparam int ARM_EXP = 2;
  localparam bit TRIG_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arm;
  logic        trace_valid;
  logic [31:0] trace_pc;
  logic [31:0] trace_instr;
  logic [31:0] trig_pc;
  logic        rd_en;
  logic [3:0]  rd_idx;

  logic [63:0] d_rd  [NI];
  logic        d_rv  [NI];
  logic [1:0]  d_st  [NI];
  logic [4:0]  d_cnt [NI];
  logic [31:0] d_cyc [NI];
  logic        d_to  [NI];
  logic        d_ha  [NI];

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int D  = P_DEPTH[g];
    localparam int IW = $clog2(D);
    logic [IW:0] cnt;
    sr_trace_buffer #(
      .ADDR_W(32), .DEPTH(D), .MODE(P_MODE[g]), .MAX_CYCLES(P_MAX[g]), .HALT_REPEAT(P_HALT[g])
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .arm(arm), .trace_valid(trace_valid),
      .trace_pc(trace_pc), .trace_instr(trace_instr), .trig_pc(trig_pc),
      .rd_en(rd_en), .rd_idx(rd_idx[IW-1:0]),
      .rd_data(d_rd[g]), .rd_valid(d_rv[g]), .state(d_st[g]), .count(cnt),
      .cycle_cnt(d_cyc[g]), .timeout(d_to[g]), .halted(d_ha[g])
    );
    assign d_cnt[g] = 5'(cnt);
  end

  // Model: every beat captured since arm is kept in order; stored entries are the last
  // (ring) or first (one-shot, which stops at DEPTH) min(n, DEPTH) of them.
  int          m_st  [NI];
  int          m_n   [NI];
  logic [31:0] m_cyc [NI];
  bit          m_to  [NI];
  bit          m_ha  [NI];
  bit          m_rv  [NI];
  logic [63:0] m_rd  [NI];
  logic [63:0] m_hist [NI][HMAX];

  function automatic int m_count(input int k);
    return (m_n[k] < P_DEPTH[k]) ? m_n[k] : P_DEPTH[k];
  endfunction

  task automatic model_step(input int k);
    int  d, cnt, idx;
    bit  same;
    d = P_DEPTH[k];
    if (!rst_n) begin
      m_st[k] = 0; m_n[k] = 0; m_cyc[k] = 0; m_to[k] = 0; m_ha[k] = 0; m_rv[k] = 0; m_rd[k] = '0;
      return;
    end
    cnt = m_count(k);
    idx = int'(rd_idx) % d;
    if (rd_en && idx < cnt) begin
      m_rv[k] = 1'b1;
      m_rd[k] = m_hist[k][m_n[k] - cnt + idx];
    end else begin
      m_rv[k] = 1'b0;
      m_rd[k] = '0;
    end
    if (arm) begin
      m_st[k] = ARM_EXP; m_n[k] = 0; m_cyc[k] = 0; m_to[k] = 0; m_ha[k] = 0;
    end else if (trace_valid && (m_st[k] == 1 || m_st[k] == 2)) begin
      if (m_cyc[k] != 32'hFFFF_FFFF) m_cyc[k] = m_cyc[k] + 1;
      if (m_st[k] == 2 || (TRIG_EN && trace_pc == trig_pc)) begin
        if (m_n[k] < HMAX) begin
          m_hist[k][m_n[k]] = {trace_pc, trace_instr};
          m_n[k] = m_n[k] + 1;
        end
        m_st[k] = 2;
        if (P_MODE[k] == 1 && m_n[k] == d) m_st[k] = 3;
        if (P_HALT[k] > 0 && m_n[k] >= P_HALT[k]) begin
          same = 1'b1;
          for (int j = 1; j < P_HALT[k]; j++)
            if (m_hist[k][m_n[k] - 1 - j][63:32] != trace_pc) same = 1'b0;
          if (same) begin
            m_ha[k] = 1'b1;
            m_st[k] = 3;
          end
        end
      end
      if (P_MAX[k] > 0 && m_cyc[k] == 32'(P_MAX[k])) begin
        m_to[k] = 1'b1;
        m_st[k] = 3;
      end
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) model_step(k);
  end

  task automatic check(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s inst%0d: got 0x%0h, expected 0x%0h (t=%0t)", name, k, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < NI; k++) begin
        check("state", k, 64'(d_st[k]), 64'(m_st[k]));
        check("count", k, 64'(d_cnt[k]), 64'(m_count(k)));
        check("cycle_cnt", k, 64'(d_cyc[k]), 64'(m_cyc[k]));
        check("timeout", k, 64'(d_to[k]), 64'(m_to[k]));
        check("halted", k, 64'(d_ha[k]), 64'(m_ha[k]));
        check("rd_valid", k, 64'(d_rv[k]), 64'(m_rv[k]));
        check("rd_data", k, d_rd[k], m_rd[k]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] pc);
    trace_valid = 1'b1;
    trace_pc    = pc;
    trace_instr = pc ^ 32'h1357_9BDF;
    tick();
    trace_valid = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic rd(input int idx);
    rd_en  = 1'b1;
    rd_idx = 4'(idx);
    tick();
    rd_en  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; arm = 1'b0; trace_valid = 1'b0; trace_pc = '0; trace_instr = '0;
    trig_pc = '0; rd_en = 1'b0; rd_idx = '0;

    // reset state
    tick();
    chk_en = 1'b1;
    repeat (3) tick();
    check("lit_reset_state", 3, 64'(d_st[3]), 64'd0);
    check("lit_reset_count", 3, 64'(d_cnt[3]), 64'd0);
    check("lit_reset_cycle", 3, 64'(d_cyc[3]), 64'd0);
    check("lit_reset_flags", 3, 64'({d_to[3], d_ha[3], d_rv[3]}), 64'd0);
    rst_n = 1'b1;
    do_arm();
    check("lit_arm_state", 3, 64'(d_st[3]), 64'(ARM_EXP));

    // ring (inst0) and one-shot (inst1), DEPTH=4, six beats 0x00..0x14
    for (int i = 0; i < 6; i++) begin
      beat(32'(4 * i));
      if (i == 3) begin
        check("lit_oneshot_done", 1, 64'(d_st[1]), 64'd3);
        check("lit_oneshot_count4", 1, 64'(d_cnt[1]), 64'd4);
      end
    end
    check("lit_ring_count", 0, 64'(d_cnt[0]), 64'd4);
    check("lit_oneshot_count", 1, 64'(d_cnt[1]), 64'd4);
    rd_en = 1'b1; rd_idx = 4'd0;
    #1;
    check("lit_rdvalid_pre", 0, 64'(d_rv[0]), 64'd0);
    tick();
    check("lit_rdvalid_post", 0, 64'(d_rv[0]), 64'd1);
    check("lit_ring_idx0", 0, 64'(d_rd[0][63:32]), 64'h08);
    check("lit_oneshot_idx0", 1, 64'(d_rd[1][63:32]), 64'h00);
    rd_idx = 4'd3;
    tick();
    check("lit_ring_idx3", 0, 64'(d_rd[0][63:32]), 64'h14);
    check("lit_oneshot_idx3", 1, 64'(d_rd[1][63:32]), 64'h0C);
    rd_en = 1'b0;
    tick();
    check("lit_rdvalid_drop", 0, 64'(d_rv[0]), 64'd0);
    rd(7);
    check("lit_oob_valid", 2, 64'(d_rv[2]), 64'd0);
    check("lit_oob_data", 2, d_rd[2], 64'd0);

    // halt detect
    do_arm();
    beat(32'h0); beat(32'h4); beat(32'h8); beat(32'h8);
    check("lit_no_halt_yet", 2, 64'(d_ha[2]), 64'd0);
    beat(32'h8);
    check("lit_halted", 2, 64'(d_ha[2]), 64'd1);
    check("lit_halt_state", 2, 64'(d_st[2]), 64'd3);
    check("lit_halt_count", 2, 64'(d_cnt[2]), 64'd5);
    beat(32'hC);
    check("lit_halt_ignore", 2, 64'(d_cnt[2]), 64'd5);

    // timeout with ring wrap
    do_arm();
    for (int i = 0; i < 35; i++) begin
      beat(32'(4 * i));
      if (i == 29) begin
        check("lit_timeout", 3, 64'(d_to[3]), 64'd1);
        check("lit_timeout_state", 3, 64'(d_st[3]), 64'd3);
        check("lit_timeout_cycle", 3, 64'(d_cyc[3]), 64'd30);
        check("lit_timeout_count", 3, 64'(d_cnt[3]), 64'd16);
      end
    end
    check("lit_nomax_cycle", 0, 64'(d_cyc[0]), 64'd35);
    rd(0);
    check("lit_timeout_idx0", 3, 64'(d_rd[3][63:32]), 64'h38);
    do_arm();
    check("lit_rearm_clear", 3, 64'({d_to[3], d_ha[3], d_cnt[3]}), 64'd0);
    check("lit_rearm_cycle", 3, 64'(d_cyc[3]), 64'd0);

    // reset mid-capture, capture only resumes after arm
    beat(32'h100); beat(32'h104);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("lit_midreset_state", 3, 64'(d_st[3]), 64'd0);
    beat(32'h108);
    check("lit_after_reset_count", 3, 64'(d_cnt[3]), 64'd0);

    // trigger stimulus, plus a beat coinciding with arm
    trig_pc = 32'h10;
    arm = 1'b1; trace_valid = 1'b1; trace_pc = 32'h40; trace_instr = 32'hDEAD_BEEF;
    tick();
    arm = 1'b0; trace_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      beat(32'(4 * i));
      if (i == 3) check("lit_trig_wait", 3, 64'(d_st[3]), TRIG_EN ? 64'd1 : 64'd2);
    end
    check("lit_trig_count", 3, 64'(d_cnt[3]), TRIG_EN ? 64'd4 : 64'd8);
    rd(0);
    check("lit_trig_idx0", 3, 64'(d_rd[3][63:32]), TRIG_EN ? 64'h10 : 64'h00);

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
